// File: rtl/median3x3_window_ctrl.sv
// median3x3_window_ctrl: raster-to-column sequencer for a 3x3 median network, realigning results
// with window-centre coordinates and bypassing the median on border centres.
module median3x3_window_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int SORT_LAT = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_pixel,
  input  logic       in_sof,
  output logic [7:0] col_top,
  output logic [7:0] col_mid,
  output logic [7:0] col_bot,
  output logic       col_valid,
  input  logic [7:0] med_in,
  output logic       out_valid,
  output logic [7:0] out_pixel,
  output logic       out_sof,
  output logic       out_eol,
  output logic       out_eof,
  output logic       sof_err
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int NLAST = IMG_W * IMG_H + IMG_W;
  localparam int NW = $clog2(NLAST + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2;
  logic [1:0] state;
  logic [XW-1:0] x, xs, cx;
  logic [YW-1:0] y, ys, cy;
  logic [NW-1:0] n, ns;
  logic [7:0] lb0 [IMG_W];
  logic [7:0] lb1 [IMG_W];
  logic [7:0] prev_raw;
  logic flush, restart, step, elig, last_px, done, x_end, cx_end, cy_end, border;
  logic [12:0] s1, pl;
  logic [12:0] pipe [SORT_LAT];
  assign in_ready = state != FLUSH;
  always_comb begin
    flush = state == FLUSH;
    restart = in_valid & in_ready & in_sof;
    step = flush | (in_valid & in_ready & (state == RUN | in_sof));
    xs = restart ? '0 : x;
    ys = restart ? '0 : y;
    ns = restart ? '0 : n;
    x_end = xs == XW'(IMG_W - 1);
    last_px = !flush & x_end & ys == YW'(IMG_H - 1);
    done = flush & ns == NW'(NLAST);
    elig = step & ns >= NW'(IMG_W + 1);
    cx_end = cx == XW'(IMG_W - 1);
    cy_end = cy == YW'(IMG_H - 1);
    border = cx == '0 | cx_end | cy == '0 | cy_end;
    pl = pipe[SORT_LAT-1];
  end
  // s1/pipe word: {valid, border, sof, eol, eof, raw centre}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      n <= '0;
      cx <= '0;
      cy <= '0;
      col_valid <= 1'b0;
      col_top <= '0;
      col_mid <= '0;
      col_bot <= '0;
      s1 <= '0;
      for (int k = 0; k < SORT_LAT; k++) pipe[k] <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof <= 1'b0;
      out_eol <= 1'b0;
      out_eof <= 1'b0;
      sof_err <= 1'b0;
    end else begin
      state <= done ? IDLE : (state == IDLE & restart) ? RUN : (state == RUN & step & last_px) ? FLUSH : state;
      if (done) begin
        x <= '0;
        y <= '0;
        n <= '0;
      end else if (step) begin
        x <= x_end ? '0 : xs + XW'(1);
        y <= x_end ? (ys == YW'(IMG_H - 1) ? '0 : ys + YW'(1)) : ys;
        n <= ns + NW'(1);
      end
      if (restart) begin
        cx <= '0;
        cy <= '0;
      end else if (elig) begin
        cx <= cx_end ? '0 : cx + XW'(1);
        cy <= cx_end ? (cy_end ? '0 : cy + YW'(1)) : cy;
      end
      col_valid <= step;
      col_top <= step & !flush ? lb1[xs] : '0;
      col_mid <= step & !flush ? lb0[xs] : '0;
      col_bot <= step & !flush ? in_pixel : '0;
      s1 <= {elig, border, elig & cx == '0 & cy == '0, elig & cx_end, elig & cx_end & cy_end, prev_raw};
      pipe[0] <= s1;
      for (int k = 1; k < SORT_LAT; k++) pipe[k] <= pipe[k-1];
      out_valid <= pl[12];
      out_pixel <= !pl[12] ? '0 : pl[11] ? pl[7:0] : med_in;
      {out_sof, out_eol, out_eof} <= pl[10:8];
      sof_err <= restart & state == RUN & (x != '0 | y != '0);
    end
  end
  // prev_raw holds lb0 read at the previous step: the centre pixel of the current step's window
  always_ff @(posedge clk) begin
    if (step) prev_raw <= lb0[xs];
    if (step & !flush) begin
      lb1[xs] <= lb0[xs];
      lb0[xs] <= in_pixel;
    end
  end
endmodule
